// File: rtl/bitfusion_mac_seq.sv
// bitfusion_mac_seq
// Job sequencer around an external combinational Bit Fusion spatial multiplier.
// A command fixes the precision mode, the sign mode and the job length N. N
// operand-word pairs then stream through a two-stage pipeline: the operand
// register feeds the multiplier, and the product register feeds the accumulator.
// One accumulated result is returned over a valid/ready handshake.
//
// Ports
//   clk, reset           clock, synchronous active-low reset
//   cmd_*                command channel (mode, sign, length)
//   op_*                 operand pair stream (A word, B word)
//   mult_mode/sign/a/b   registered drive to the external multiplier
//   mult_out             combinational multiplier product
//   res_*                result channel (accumulated sum, sticky overflow)
//   busy                 high whenever the sequencer is not idle
//
// state  | meaning
// IDLE   | waiting for a command; cmd_ready high
// RUN    | accepting operand pairs until N have been issued
// DRAIN  | last pair issued, waiting for its product to be accumulated
// DONE   | result presented; held until res_ready

module bitfusion_mac_seq #(
    parameter int PRECISION   = 8,
    parameter int L_PRECISION = 2,
    parameter int IN_WIDTH    = (PRECISION / L_PRECISION) * PRECISION,
    parameter int MODE_WIDTH  = 2 * $clog2(PRECISION / L_PRECISION),
    parameter int OUT_WIDTH   = 2 * PRECISION,
    parameter int ACC_WIDTH   = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [MODE_WIDTH-1:0] cmd_mode,
    input  logic [1:0]            cmd_sign,
    input  logic [CNT_WIDTH-1:0]  cmd_len,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [IN_WIDTH-1:0]   op_a,
    input  logic [IN_WIDTH-1:0]   op_b,
    output logic [MODE_WIDTH-1:0] mult_mode,
    output logic [1:0]            mult_sign,
    output logic [IN_WIDTH-1:0]   mult_a,
    output logic [IN_WIDTH-1:0]   mult_b,
    input  logic [OUT_WIDTH-1:0]  mult_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic                  res_ovf,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [MODE_WIDTH-1:0] mode_q, mode_d;
    logic [1:0]            sign_q, sign_d;
    logic [IN_WIDTH-1:0]   a_q, a_d;
    logic [IN_WIDTH-1:0]   b_q, b_d;
    logic [OUT_WIDTH-1:0]  prod_q, prod_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s2_valid_q, s2_valid_d;

    logic                  op_fire;
    logic                  sign_any;
    logic [ACC_WIDTH-1:0]  addend;
    logic [ACC_WIDTH:0]    sum_full;
    logic                  ovf_now;

    assign op_fire  = op_valid && (state_q == ST_RUN);
    assign sign_any = (sign_q != 2'b00);

    // Any signed operand makes the product a signed quantity, so extend its sign.
    assign addend   = sign_any ? ACC_WIDTH'($signed(prod_q)) : ACC_WIDTH'(prod_q);
    assign sum_full = {1'b0, acc_q} + {1'b0, addend};

    // Signed: same-sign addends giving an opposite-sign sum. Unsigned: carry out.
    assign ovf_now  = sign_any
                    ? ((acc_q[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                       (sum_full[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                    : sum_full[ACC_WIDTH];

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        sign_d     = sign_q;
        a_d        = a_q;
        b_d        = b_q;
        prod_d     = prod_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        s1_valid_d = op_fire;
        s2_valid_d = s1_valid_q;

        if (op_fire) begin
            a_d   = op_a;
            b_d   = op_b;
            cnt_d = cnt_q + 1'b1;
        end

        if (s1_valid_q) begin
            prod_d = mult_out;
        end

        if (s2_valid_q) begin
            acc_d = sum_full[ACC_WIDTH-1:0];
            ovf_d = ovf_q | ovf_now;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mode_d  = cmd_mode;
                    sign_d  = cmd_sign;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    len_d   = cmd_len;
                    state_d = (cmd_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (op_fire && ((cnt_q + 1'b1) == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // No beats enter during DRAIN, so s2 alone with s1 empty marks
                // the edge performing the final accumulate.
                if (s2_valid_q && !s1_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            sign_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            len_q      <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            sign_q     <= sign_d;
            a_q        <= a_d;
            b_q        <= b_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign op_ready  = (state_q == ST_RUN);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign res_data  = acc_q;
    assign res_ovf   = ovf_q;
    assign mult_mode = mode_q;
    assign mult_sign = sign_q;
    assign mult_a    = a_q;
    assign mult_b    = b_q;

endmodule

// File: tb/tb_bitfusion_mac_seq.sv
// Bench for bitfusion_mac_seq. Two instances (32-bit and 17-bit accumulators)
// share all inputs and run in lockstep; each drives its own multiplier stand-in
// that forms the product of the low bytes with the requested signedness.

module tb_bitfusion_mac_seq;

    localparam int CLK_P = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [3:0]  cmd_mode;
    logic [1:0]  cmd_sign;
    logic [15:0] cmd_len;
    logic        op_valid;
    logic [31:0] op_a, op_b;
    logic        res_ready;

    logic        cmd_ready, op_ready, res_valid, res_ovf, busy;
    logic [3:0]  mult_mode;
    logic [1:0]  mult_sign;
    logic [31:0] mult_a, mult_b;
    logic [15:0] mult_out;
    logic [31:0] res_data;

    logic        cmd_ready17, op_ready17, res_valid17, res_ovf17, busy17;
    logic [3:0]  mult_mode17;
    logic [1:0]  mult_sign17;
    logic [31:0] mult_a17, mult_b17;
    logic [15:0] mult_out17;
    logic [16:0] res_data17;

    int checks   = 0;
    int failures = 0;

    always #(CLK_P / 2) clk = ~clk;

    function automatic int prod_val(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        int av, bv;
        av = s[1] ? int'($signed(a)) : int'({24'd0, a});
        bv = s[0] ? int'($signed(b)) : int'({24'd0, b});
        return av * bv;
    endfunction

    function automatic logic [15:0] mult_stub(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        int p;
        p = prod_val(a, b, s);
        return p[15:0];
    endfunction

    assign mult_out   = mult_stub(mult_a[7:0], mult_b[7:0], mult_sign);
    assign mult_out17 = mult_stub(mult_a17[7:0], mult_b17[7:0], mult_sign17);

    bitfusion_mac_seq u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_sign(cmd_sign), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mult_mode(mult_mode), .mult_sign(mult_sign), .mult_a(mult_a), .mult_b(mult_b),
        .mult_out(mult_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .busy(busy)
    );

    bitfusion_mac_seq #(.ACC_WIDTH(17)) u_dut17 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready17), .cmd_mode(cmd_mode),
        .cmd_sign(cmd_sign), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready17), .op_a(op_a), .op_b(op_b),
        .mult_mode(mult_mode17), .mult_sign(mult_sign17), .mult_a(mult_a17), .mult_b(mult_b17),
        .mult_out(mult_out17),
        .res_valid(res_valid17), .res_ready(res_ready), .res_data(res_data17),
        .res_ovf(res_ovf17), .busy(busy17)
    );

    int op_rdy_cnt = 0;
    int rv_cnt     = 0;
    always @(negedge clk) begin
        if (op_ready) op_rdy_cnt = op_rdy_cnt + 1;
        if (res_valid || res_valid17) rv_cnt = rv_cnt + 1;
    end

    // Job stimulus and observations
    logic [31:0] beat_a[$];
    logic [31:0] beat_b[$];
    bit          r_timeout, r_hold_ok, r_cmd_after, r_rv_after;
    int          r_lat, r_first_wait, r_span, r_op_rdy;
    logic [31:0] r_data;
    logic [16:0] r_data17;
    logic        r_ovf, r_ovf17;
    logic [3:0]  r_mode;
    logic [1:0]  r_sign;
    longint      e_data32, e_data17;
    bit          e_ovf32, e_ovf17;

    // Reference: integer sum of true products, wrapped to width w, with the
    // overflow flag taken from range excursions of each partial sum.
    task automatic ref_calc(input logic [1:0] s, input int len, input int w,
                            output longint data, output bit ovf);
        longint m, acc, sv, p;
        m   = longint'(1) << w;
        acc = 0;
        ovf = 0;
        for (int i = 0; i < len; i++) begin
            p = longint'(prod_val(beat_a[i][7:0], beat_b[i][7:0], s));
            if (s != 2'b00) begin
                sv = (acc >= m / 2) ? acc - m : acc;
                sv = sv + p;
                if (sv >= m / 2 || sv < -(m / 2)) ovf = 1;
            end else begin
                sv = acc + p;
                if (sv >= m) ovf = 1;
            end
            acc = ((sv % m) + m) % m;
        end
        data = acc;
    endtask

    task automatic calc_all(input logic [1:0] s, input int len);
        ref_calc(s, len, 32, e_data32, e_ovf32);
        ref_calc(s, len, 17, e_data17, e_ovf17);
    endtask

    // Drives one complete job; every wait is bounded and sets r_timeout.
    task automatic drive_job(input logic [3:0] mode, input logic [1:0] s, input int len,
                             input int gap, input int hold);
        int     n, start;
        longint t_first, t_last;
        logic [31:0] d0;
        logic        o0;
        r_timeout = 0; r_hold_ok = 1; r_lat = -1; r_first_wait = -1; r_span = -1;
        t_first = 0; t_last = 0;
        start = op_rdy_cnt;
        cmd_valid = 1; cmd_mode = mode; cmd_sign = s; cmd_len = len[15:0];
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) begin r_timeout = 1; cmd_valid = 0; return; end
        @(posedge clk); #1;
        cmd_valid = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin op_valid = 0; @(posedge clk); #1; end
            end
            op_valid = 1; op_a = beat_a[i]; op_b = beat_b[i];
            n = 0;
            while (!op_ready && n < 50) begin @(posedge clk); #1; n++; end
            if (!op_ready) begin r_timeout = 1; op_valid = 0; return; end
            if (i == 0) r_first_wait = n;
            @(posedge clk);
            if (i == 0) t_first = longint'($time);
            t_last = longint'($time);
            #1;
        end
        op_valid = 0;
        r_span = int'((t_last - t_first) / CLK_P);
        n = 0;
        while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!res_valid) begin r_timeout = 1; return; end
        r_lat  = n;
        r_mode = mult_mode;
        r_sign = mult_sign;
        d0 = res_data; o0 = res_ovf;
        res_ready = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!res_valid || res_data !== d0 || res_ovf !== o0 || cmd_ready !== 1'b0)
                r_hold_ok = 0;
        end
        r_data = res_data; r_ovf = res_ovf; r_data17 = res_data17; r_ovf17 = res_ovf17;
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        r_cmd_after = cmd_ready;
        r_rv_after  = res_valid;
        r_op_rdy    = op_rdy_cnt - start;
    endtask

    task automatic test_reset();
        reset = 0; cmd_valid = 0; cmd_mode = 0; cmd_sign = 0; cmd_len = 0;
        op_valid = 0; op_a = 0; op_b = 0; res_ready = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        checks++;
        if (cmd_ready !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: got cmd_ready=%b op_ready=%b res_valid=%b busy=%b want 1 0 0 0",
                     cmd_ready, op_ready, res_valid, busy);
        end
        checks++;
        if (res_data !== 32'd0 || res_ovf !== 1'b0 || mult_mode !== 4'd0 || mult_sign !== 2'd0 ||
            mult_a !== 32'd0 || mult_b !== 32'd0 || res_data17 !== 17'd0 || mult_a17 !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs: got res_data=%h ovf=%b mode=%h sign=%b a=%h b=%h want all zero",
                     res_data, res_ovf, mult_mode, mult_sign, mult_a, mult_b);
        end
    endtask

    task automatic test_signed_single();
        beat_a = {32'h0000_00FF}; beat_b = {32'h0000_0003};
        calc_all(2'b11, 1);
        drive_job(4'd0, 2'b11, 1, 0, 0);
        checks++;
        if (r_timeout) begin failures++; $display("FAIL single_timeout: job did not complete"); end
        checks++;
        if (r_data !== 32'hFFFF_FFFD || {32'd0, r_data} !== e_data32) begin
            failures++;
            $display("FAIL single_data: got %h want FFFFFFFD", r_data);
        end
        checks++;
        if (r_first_wait !== 0 || r_lat !== 2) begin
            failures++;
            $display("FAIL single_timing: got op_wait=%0d lat=%0d want 0 2", r_first_wait, r_lat);
        end
        checks++;
        if (r_mode !== 4'd0 || r_sign !== 2'b11 || r_cmd_after !== 1'b1 || r_rv_after !== 1'b0) begin
            failures++;
            $display("FAIL single_ctrl: got mode=%h sign=%b cmd_after=%b rv_after=%b want 0 11 1 0",
                     r_mode, r_sign, r_cmd_after, r_rv_after);
        end
    endtask

    task automatic test_unsigned_b2b();
        beat_a = {}; beat_b = {};
        for (int i = 0; i < 4; i++) begin beat_a.push_back(32'hFF); beat_b.push_back(32'hFF); end
        calc_all(2'b00, 4);
        drive_job(4'd0, 2'b00, 4, 0, 0);
        checks++;
        if (r_timeout || r_data !== 32'd260100 || {32'd0, r_data} !== e_data32 || r_ovf !== 1'b0) begin
            failures++;
            $display("FAIL b2b_data: got %0d ovf=%b to=%b want 260100 0 0", r_data, r_ovf, r_timeout);
        end
        checks++;
        if (r_op_rdy !== 4 || r_span !== 3 || r_lat !== 2) begin
            failures++;
            $display("FAIL b2b_timing: got op_ready_cycles=%0d span=%0d lat=%0d want 4 3 2",
                     r_op_rdy, r_span, r_lat);
        end
    endtask

    task automatic test_zero_len();
        drive_job(4'b1010, 2'b01, 0, 0, 0);
        checks++;
        if (r_timeout || r_data !== 32'd0 || r_lat !== 0 || r_op_rdy !== 0) begin
            failures++;
            $display("FAIL zero_len: got data=%h lat=%0d op_ready_cycles=%0d to=%b want 0 0 0 0",
                     r_data, r_lat, r_op_rdy, r_timeout);
        end
        checks++;
        if (r_mode !== 4'b1010 || r_sign !== 2'b01) begin
            failures++;
            $display("FAIL zero_len_mode: got mode=%b sign=%b want 1010 01", r_mode, r_sign);
        end
    endtask

    task automatic test_bubbled();
        beat_a = {32'h0A, 32'hFB, 32'h07};
        beat_b = {32'h0A, 32'h0A, 32'h01};
        calc_all(2'b11, 3);
        drive_job(4'd0, 2'b11, 3, 2, 5);
        checks++;
        if (r_timeout || r_data !== 32'd57 || {32'd0, r_data} !== e_data32) begin
            failures++;
            $display("FAIL bubble_data: got %0d to=%b want 57", r_data, r_timeout);
        end
        checks++;
        if (r_hold_ok !== 1'b1 || r_lat !== 2 || r_span !== 6) begin
            failures++;
            $display("FAIL bubble_hold: got hold_ok=%b lat=%0d span=%0d want 1 2 6", r_hold_ok, r_lat, r_span);
        end
    endtask

    task automatic test_ovf();
        beat_a = {}; beat_b = {};
        for (int i = 0; i < 6; i++) begin beat_a.push_back(32'h7F); beat_b.push_back(32'h7F); end
        calc_all(2'b11, 6);
        drive_job(4'd0, 2'b11, 6, 0, 0);
        checks++;
        if (r_timeout || r_ovf17 !== 1'b1 || {47'd0, r_data17} !== e_data17 || r_data17 !== 17'd96774) begin
            failures++;
            $display("FAIL ovf17: got data=%0d ovf=%b to=%b want 96774 1", r_data17, r_ovf17, r_timeout);
        end
        checks++;
        if (r_data !== 32'd96774 || r_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf32: got data=%0d ovf=%b want 96774 0", r_data, r_ovf);
        end
        beat_a = {32'h02}; beat_b = {32'h03};
        drive_job(4'd0, 2'b11, 1, 0, 0);
        checks++;
        if (r_ovf17 !== 1'b0 || r_data17 !== 17'd6) begin
            failures++;
            $display("FAIL ovf_clear: got data=%0d ovf=%b want 6 0", r_data17, r_ovf17);
        end
    endtask

    task automatic test_reset_mid_job();
        int rv0;
        cmd_valid = 1; cmd_mode = 4'd0; cmd_sign = 2'b11; cmd_len = 16'd5;
        @(posedge clk); #1;
        cmd_valid = 0;
        op_valid = 1; op_a = 32'h11; op_b = 32'h22;
        @(posedge clk); #1;
        op_a = 32'h33; op_b = 32'h44;
        @(posedge clk); #1;
        op_valid = 0; reset = 0;
        @(posedge clk); #1;
        reset = 1;
        checks++;
        if (cmd_ready !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 ||
            res_data !== 32'd0 || res_ovf !== 1'b0 || mult_a !== 32'd0 || mult_mode17 !== 4'd0) begin
            failures++;
            $display("FAIL midreset_state: got cmd_ready=%b op_ready=%b res_valid=%b busy=%b data=%h a=%h",
                     cmd_ready, op_ready, res_valid, busy, res_data, mult_a);
        end
        rv0 = rv_cnt;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (rv_cnt !== rv0) begin
            failures++;
            $display("FAIL midreset_norv: got %0d res_valid cycles want 0", rv_cnt - rv0);
        end
        beat_a = {32'h03}; beat_b = {32'hFB};
        calc_all(2'b11, 1);
        drive_job(4'd0, 2'b11, 1, 0, 0);
        checks++;
        if (r_timeout || r_data !== 32'hFFFF_FFF1 || {32'd0, r_data} !== e_data32) begin
            failures++;
            $display("FAIL midreset_next: got %h to=%b want FFFFFFF1", r_data, r_timeout);
        end
    endtask

    task automatic test_random();
        logic [1:0] s;
        logic [3:0] m;
        int len, gap, hold;
        for (int j = 0; j < 10; j++) begin
            s = 2'($urandom_range(0, 3));
            m = 4'($urandom_range(0, 15));
            len  = $urandom_range(1, 8);
            gap  = $urandom_range(0, 2);
            hold = $urandom_range(0, 3);
            beat_a = {}; beat_b = {};
            for (int i = 0; i < len; i++) begin
                beat_a.push_back($urandom); beat_b.push_back($urandom);
            end
            calc_all(s, len);
            drive_job(m, s, len, gap, hold);
            checks++;
            if (r_timeout || {32'd0, r_data} !== e_data32 || r_ovf !== e_ovf32) begin
                failures++;
                $display("FAIL rand32[%0d]: got %h ovf=%b to=%b want %h ovf=%b",
                         j, r_data, r_ovf, r_timeout, e_data32[31:0], e_ovf32);
            end
            checks++;
            if ({47'd0, r_data17} !== e_data17 || r_ovf17 !== e_ovf17) begin
                failures++;
                $display("FAIL rand17[%0d]: got %h ovf=%b want %h ovf=%b",
                         j, r_data17, r_ovf17, e_data17[16:0], e_ovf17);
            end
            checks++;
            if (r_mode !== m || r_sign !== s || r_lat !== 2 || r_hold_ok !== 1'b1) begin
                failures++;
                $display("FAIL randctl[%0d]: got mode=%h sign=%b lat=%0d hold_ok=%b want %h %b 2 1",
                         j, r_mode, r_sign, r_lat, r_hold_ok, m, s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_single();
        test_unsigned_b2b();
        test_zero_len();
        test_bubbled();
        test_ovf();
        test_reset_mid_job();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
